// File: rtl/led_pattern_monitor.sv
// Decodes a one-hot LED bus back into position, step delta, direction and step
// timing, flagging non-one-hot patterns, illegal steps and stalls.
module led_pattern_monitor #(
    parameter int unsigned PERIOD_W = 32,
    parameter int unsigned COUNT_W  = 16,
    parameter int unsigned TIMEOUT  = 4000000
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [7:0]          led_in,
    input  logic                clear,
    output logic [2:0]          pos,
    output logic                pos_valid,
    output logic                step_valid,
    output logic [2:0]          step_delta,
    output logic                dir,
    output logic [PERIOD_W-1:0] period,
    output logic [COUNT_W-1:0]  step_count,
    output logic                err_onehot,
    output logic                err_step,
    output logic                stall
);

    localparam int unsigned LED_W = 8;
    localparam int unsigned IDX_W = 3;
    localparam logic [PERIOD_W-1:0] CYC_MAX  = '1;
    localparam logic [PERIOD_W-1:0] STALL_AT = PERIOD_W'(TIMEOUT - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        TRACK = 1'b1
    } state_e;

    state_e              state_q, state_d;
    logic [LED_W-1:0]    s1_q, s2_q;
    logic [LED_W-1:0]    last_q, last_d;
    logic [PERIOD_W-1:0] cyc_q, cyc_d;
    logic [IDX_W-1:0]    pos_q, pos_d;
    logic                pos_valid_q, pos_valid_d;
    logic                step_valid_q, step_valid_d;
    logic [IDX_W-1:0]    step_delta_q, step_delta_d;
    logic                dir_q, dir_d;
    logic [PERIOD_W-1:0] period_q, period_d;
    logic [COUNT_W-1:0]  step_count_q, step_count_d;
    logic                err_onehot_q, err_onehot_d;
    logic                err_step_q, err_step_d;
    logic                stall_q, stall_d;

    logic                change_c;
    logic                onehot_c;
    logic [IDX_W-1:0]    new_idx_c;
    logic [IDX_W-1:0]    raw_c;
    logic                legal_c;

    // Index of the highest set bit; only meaningful when the value is one-hot.
    function automatic logic [IDX_W-1:0] encode(input logic [LED_W-1:0] v);
        logic [IDX_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < int'(LED_W); i++) begin
            if (v[i]) begin
                idx = IDX_W'(i);
            end
        end
        return idx;
    endfunction

    assign change_c  = (s2_q != last_q);
    assign onehot_c  = (s2_q != '0) && ((s2_q & (s2_q - LED_W'(1))) == '0);
    assign new_idx_c = encode(s2_q);
    assign raw_c     = new_idx_c - pos_q;
    assign legal_c   = (raw_c == 3'd1) || (raw_c == 3'd2) ||
                       (raw_c == 3'd6) || (raw_c == 3'd7);

    // Next-state and output logic; sticky flags and counters honour clear first.
    always_comb begin
        state_d      = state_q;
        last_d       = change_c ? s2_q : last_q;
        cyc_d        = cyc_q;
        pos_d        = pos_q;
        pos_valid_d  = pos_valid_q;
        step_valid_d = 1'b0;
        step_delta_d = step_delta_q;
        dir_d        = dir_q;
        period_d     = clear ? '0 : period_q;
        step_count_d = clear ? '0 : step_count_q;
        err_onehot_d = err_onehot_q & ~clear;
        err_step_d   = err_step_q & ~clear;
        stall_d      = stall_q & ~clear;

        unique case (state_q)
            IDLE: begin
                if (change_c) begin
                    if (onehot_c) begin
                        pos_d       = new_idx_c;
                        pos_valid_d = 1'b1;
                        cyc_d       = '0;
                        stall_d     = 1'b0;
                        state_d     = TRACK;
                    end else begin
                        err_onehot_d = 1'b1;
                    end
                end
            end
            TRACK: begin
                if (change_c) begin
                    stall_d = 1'b0;
                    if (onehot_c) begin
                        pos_d        = new_idx_c;
                        step_valid_d = 1'b1;
                        step_delta_d = raw_c;
                        step_count_d = step_count_d + COUNT_W'(1);
                        period_d     = (cyc_q == CYC_MAX) ? CYC_MAX : cyc_q + PERIOD_W'(1);
                        cyc_d        = '0;
                        if (!legal_c) begin
                            err_step_d = 1'b1;
                        end
                        if (raw_c == 3'd2) begin
                            dir_d = 1'b0;
                        end else if (raw_c == 3'd6) begin
                            dir_d = 1'b1;
                        end
                    end else begin
                        err_onehot_d = 1'b1;
                        pos_valid_d  = 1'b0;
                        state_d      = IDLE;
                    end
                end else begin
                    cyc_d = (cyc_q == CYC_MAX) ? CYC_MAX : cyc_q + PERIOD_W'(1);
                    if ((cyc_q >= STALL_AT) && !clear) begin
                        stall_d = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            s1_q         <= '0;
            s2_q         <= '0;
            last_q       <= '0;
            cyc_q        <= '0;
            pos_q        <= '0;
            pos_valid_q  <= 1'b0;
            step_valid_q <= 1'b0;
            step_delta_q <= '0;
            dir_q        <= 1'b0;
            period_q     <= '0;
            step_count_q <= '0;
            err_onehot_q <= 1'b0;
            err_step_q   <= 1'b0;
            stall_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            s1_q         <= led_in;
            s2_q         <= s1_q;
            last_q       <= last_d;
            cyc_q        <= cyc_d;
            pos_q        <= pos_d;
            pos_valid_q  <= pos_valid_d;
            step_valid_q <= step_valid_d;
            step_delta_q <= step_delta_d;
            dir_q        <= dir_d;
            period_q     <= period_d;
            step_count_q <= step_count_d;
            err_onehot_q <= err_onehot_d;
            err_step_q   <= err_step_d;
            stall_q      <= stall_d;
        end
    end

    assign pos        = pos_q;
    assign pos_valid  = pos_valid_q;
    assign step_valid = step_valid_q;
    assign step_delta = step_delta_q;
    assign dir        = dir_q;
    assign period     = period_q;
    assign step_count = step_count_q;
    assign err_onehot = err_onehot_q;
    assign err_step   = err_step_q;
    assign stall      = stall_q;

endmodule
